axil_regbank: RTL
=================

AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI4-Lite data width (32 or 64).
REQ-002 SHALL have parameter NUM_REGS, default 8, register count (power of two, 2..64).
REQ-003 SHALL have parameter RO_MASK, default 0, NUM_REGS-bit; bit r=1 makes register r read-only, value taken from status_i.
REQ-004 SHALL have parameter W1C_MASK, default 0, NUM_REGS-bit; bit r=1 makes register r sticky: bits set by set_i, cleared by writing 1.
REQ-005 SHALL have parameter ADDR_W, default log2(NUM_REGS)+log2(DATA_W/8)+1, byte address width.
REQ-006 ACLK  in  1  sole clock, rising edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 S_AXI_AWADDR in ADDR_W; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1  write address channel.
REQ-009 S_AXI_WDATA in DATA_W; S_AXI_WSTRB in DATA_W/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1  write data channel.
REQ-010 S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1  write response channel.
REQ-011 S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1  read address channel.
REQ-012 S_AXI_RDATA out DATA_W; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1  read data channel.
REQ-013 reg_q  out  NUM_REGS*DATA_W  current register contents, register r at [r*DATA_W +: DATA_W].
REQ-014 reg_wr_pulse  out  NUM_REGS  one-cycle pulse, register r committed by a write.
REQ-015 status_i  in  NUM_REGS*DATA_W  live values for RO registers.
REQ-016 set_i  in  NUM_REGS*DATA_W  per-bit set strobes for W1C registers.

Function
REQ-017 Write FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; AW and W SHALL be accepted independently in any order or the same cycle.
REQ-018 AWREADY high in W_IDLE/W_HAVE_W; WREADY high in W_IDLE/W_HAVE_AW; both low in W_RESP.
REQ-019 Commit SHALL occur the cycle after both captured; BVALID asserts that cycle and holds until BREADY, then return to W_IDLE.
REQ-020 Word index = addr[ADDR_W-1:log2(DATA_W/8)]; index >= NUM_REGS -> BRESP/RRESP=SLVERR(2'b10), no state change, RDATA=0.
REQ-021 RW registers: byte lane b updated only where WSTRB[b]=1; WSTRB=0 SHALL commit nothing but still respond OKAY and pulse reg_wr_pulse.
REQ-022 RO registers: writes ignored, BRESP=OKAY, no pulse.
REQ-023 W1C registers: next = (cur & ~(wdata & strobe mask)) | set_i; set wins over simultaneous clear.
REQ-024 Read FSM states R_IDLE, R_DATA; ARREADY high only in R_IDLE; RDATA/RRESP registered, RVALID one cycle after AR handshake, held stable until RREADY.
REQ-025 RO read returns status_i sampled at AR handshake cycle; read and commit to same register in same cycle SHALL return pre-commit value.
REQ-026 Unaligned low address bits SHALL be ignored.

Reset
REQ-027 ARESET SHALL asynchronously clear all registers, reg_q, reg_wr_pulse, BVALID, RVALID, RDATA, BRESP, RRESP to 0 and both FSMs to idle; AWREADY/WREADY/ARREADY low during reset, high the first cycle after release.
REQ-028 Reset mid-transaction SHALL discard the transaction with no response.

Structure
REQ-029 Package axil_regbank_pkg SHALL hold RESP_OKAY/RESP_SLVERR constants and FSM state enums.
REQ-030 Sub-module axil_regbank_wstrb_merge SHALL implement per-register byte/W1C merge, instantiated per register.

Verification
REQ-031 Write 0x00000001..0x00000004 to addr 0x0..0xC, read back -> identical data, all OKAY.
REQ-032 W before AW by 3 cycles, data 0xA5A5A5A5 to 0x4 -> single commit, reg_wr_pulse[1] one cycle, BRESP OKAY.
REQ-033 WSTRB=4'b0010 data 0x0000BB00 onto 0x11223344 -> register reads 0x1122BB44.
REQ-034 Read/write addr 0x20 (NUM_REGS=8) -> SLVERR, RDATA=0, reg_q unchanged.
REQ-035 W1C reg: set_i bit0 pulse, read 0x1; write 0x1 with set_i bit0 same commit cycle -> bit stays 1.
REQ-036 BREADY/RREADY held low 10 cycles -> BVALID/RVALID and data stable; ARESET asserted mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// ---------------------------------------------------------------------------
// axil_regbank_pkg
// Shared definitions for the AXI4-Lite register bank:
//   RESP_OKAY / RESP_SLVERR  AXI response codes
//   w_state_e                write-channel FSM states
//   r_state_e                read-channel FSM states
// ---------------------------------------------------------------------------
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axil_regbank_if.sv
// ---------------------------------------------------------------------------
// axil_regbank_if
// AXI4-Lite bus bundle for the register bank.
//   DATA_W  data width (32 or 64), ADDR_W byte address width
//   master  modport: drives AW/W/AR payload+valid, BREADY, RREADY
//   slave   modport: drives AWREADY, WREADY, ARREADY, B and R channels
// ---------------------------------------------------------------------------
interface axil_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/axil_regbank_wstrb_merge.sv
// ---------------------------------------------------------------------------
// axil_regbank_wstrb_merge
// Next-value logic for one register of the bank.
//   IS_RO   register mirrors status every cycle; writes have no effect
//   IS_W1C  sticky bits: set by set_bits, cleared by written ones
//   else    read/write register updated per byte lane on commit
// Ports:
//   commit    write to this register is being committed this cycle
//   cur       current stored value
//   wdata     write data, wstrb byte strobes
//   set_bits  per-bit set strobes (W1C only)
//   status    live value (RO only)
//   nxt       value to store at the next clock edge
// ---------------------------------------------------------------------------
module axil_regbank_wstrb_merge
  import axil_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit IS_RO  = 1'b0,
  parameter bit IS_W1C = 1'b0
) (
  input  logic                commit,
  input  logic [DATA_W-1:0]   cur,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   set_bits,
  input  logic [DATA_W-1:0]   status,
  output logic [DATA_W-1:0]   nxt
);

  logic [DATA_W-1:0] byte_mask;

  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
    assign byte_mask[gi*8 +: 8] = {8{wstrb[gi]}};
  end

  always_comb begin
    nxt = cur;
    if (IS_RO) begin
      nxt = status;
    end else if (IS_W1C) begin
      // Set is OR-ed last so it wins over a clear in the same cycle.
      nxt = (cur & ~(commit ? (wdata & byte_mask) : '0)) | set_bits;
    end else if (commit) begin
      nxt = (cur & ~byte_mask) | (wdata & byte_mask);
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// ---------------------------------------------------------------------------
// axil_regbank
// AXI4-Lite slave exposing NUM_REGS registers of DATA_W bits. Registers are
// read/write, read-only (RO_MASK, value from status_i) or sticky W1C
// (W1C_MASK, bits set by set_i and cleared by writing 1).
// Ports:
//   ACLK, ARESET   clock and asynchronous active-high reset
//   s_axi          AXI4-Lite slave bus
//   reg_q          register contents, register r at [r*DATA_W +: DATA_W]
//   reg_wr_pulse   one-cycle pulse per register committed by a write
//   status_i       live values for RO registers
//   set_i          per-bit set strobes for W1C registers
// Write commit happens on the edge that completes the second of AW/W; the
// following cycle shows the new contents, the pulse and BVALID together.
// ---------------------------------------------------------------------------
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
  parameter int                  ADDR_W   = $clog2(NUM_REGS) + $clog2(DATA_W / 8) + 1
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axil_regbank_if.slave                s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0]   status_i,
  input  logic [NUM_REGS*DATA_W-1:0]   set_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  // ---------------- write channel ----------------
  w_state_e          w_state_reg, w_state_next;
  logic [IDX_W-1:0]  aw_idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic [1:0]        bresp_reg;
  logic              aw_ready, w_ready, b_valid;
  logic              aw_hs, w_hs, commit;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_in_range;

  assign aw_hs = s_axi.S_AXI_AWVALID & aw_ready;
  assign w_hs  = s_axi.S_AXI_WVALID & w_ready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state_reg <= W_IDLE;
    else        w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    unique case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_next = W_RESP;
        else if (aw_hs)    w_state_next = W_HAVE_AW;
        else if (w_hs)     w_state_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_state_next = W_RESP;
      W_HAVE_W:  if (aw_hs) w_state_next = W_RESP;
      W_RESP:    if (s_axi.S_AXI_BREADY) w_state_next = W_IDLE;
      default:   w_state_next = W_IDLE;
    endcase
  end

  // Readies are gated by ARESET so they drop immediately while in reset.
  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        aw_ready = ~ARESET;
        w_ready  = ~ARESET;
      end
      W_HAVE_AW: w_ready  = ~ARESET;
      W_HAVE_W:  aw_ready = ~ARESET;
      W_RESP:    b_valid  = 1'b1;
      default: ;
    endcase
  end

  // Commit on the edge that captures the last of AW/W; the fields of the
  // channel handshaking right now come straight from the bus.
  assign commit      = (w_state_next == W_RESP) && (w_state_reg != W_RESP);
  assign wr_idx      = aw_hs ? s_axi.S_AXI_AWADDR[ADDR_W-1:LSB] : aw_idx_reg;
  assign wr_data     = w_hs ? s_axi.S_AXI_WDATA : wdata_reg;
  assign wr_strb     = w_hs ? s_axi.S_AXI_WSTRB : wstrb_reg;
  assign wr_in_range = 32'(wr_idx) < 32'(NUM_REGS);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      bresp_reg  <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_idx_reg <= s_axi.S_AXI_AWADDR[ADDR_W-1:LSB];
      if (w_hs) begin
        wdata_reg <= s_axi.S_AXI_WDATA;
        wstrb_reg <= s_axi.S_AXI_WSTRB;
      end
      if (commit) bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- register array ----------------
  logic [NUM_REGS-1:0] reg_commit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] q_next;
    logic              pulse_reg;

    assign reg_commit[gi] = commit & wr_in_range & (wr_idx == IDX_W'(gi));

    axil_regbank_wstrb_merge #(
      .DATA_W (DATA_W),
      .IS_RO  (RO_MASK[gi]),
      .IS_W1C (W1C_MASK[gi])
    ) u_merge (
      .commit   (reg_commit[gi]),
      .cur      (q_reg),
      .wdata    (wr_data),
      .wstrb    (wr_strb),
      .set_bits (set_i[gi*DATA_W +: DATA_W]),
      .status   (status_i[gi*DATA_W +: DATA_W]),
      .nxt      (q_next)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        q_reg     <= '0;
        pulse_reg <= 1'b0;
      end else begin
        q_reg     <= q_next;
        pulse_reg <= reg_commit[gi] & ~RO_MASK[gi];
      end
    end

    assign reg_q[gi*DATA_W +: DATA_W] = q_reg;
    assign reg_wr_pulse[gi]           = pulse_reg;
  end

  // ---------------- read channel ----------------
  r_state_e          r_state_reg, r_state_next;
  logic              ar_ready, r_valid, ar_hs;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;

  assign ar_hs       = s_axi.S_AXI_ARVALID & ar_ready;
  assign rd_idx      = s_axi.S_AXI_ARADDR[ADDR_W-1:LSB];
  assign rd_in_range = 32'(rd_idx) < 32'(NUM_REGS);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state_reg <= R_IDLE;
    else        r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    unique case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (r_state_reg == R_IDLE) & ~ARESET;
    r_valid  = (r_state_reg == R_DATA);
  end

  // Stored values are the pre-commit contents, so a read racing a write to
  // the same register returns the old value.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_idx == IDX_W'(r)) begin
        rd_word = RO_MASK[r] ? status_i[r*DATA_W +: DATA_W] : reg_q[r*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_in_range ? rd_word : '0;
      rresp_reg <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Sub-word address bits do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = bresp_reg;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = rresp_reg;

endmodule
